// File: rtl/alu_seq.sv
// alu_seq: registered WIDTH-bit ALU with an iterative shift-add multiply and valid/ready handshakes.
// Defining ALU_ACC_EN adds a use_acc port that selects an internal accumulator as operand A.
module alu_seq #(
    parameter int WIDTH = 8,
    parameter int CNT_W = $clog2(WIDTH) + 1
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    input  logic [3:0]       op,
`ifdef ALU_ACC_EN
    input  logic             use_acc,
`endif
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH-1:0] result,
    output logic             carry,
    output logic             zero,
    output logic             neg,
    output logic             ovf,
    output logic             err
);
    localparam logic [0:0] S_IDLE = 1'b0;
    localparam logic [0:0] S_MUL  = 1'b1;
    localparam logic [3:0] OP_ADD = 4'd0;
    localparam logic [3:0] OP_SUB = 4'd1;
    localparam logic [3:0] OP_AND = 4'd2;
    localparam logic [3:0] OP_OR  = 4'd3;
    localparam logic [3:0] OP_XOR = 4'd4;
    localparam logic [3:0] OP_NOT = 4'd5;
    localparam logic [3:0] OP_SHL = 4'd6;
    localparam logic [3:0] OP_SHR = 4'd7;
    localparam logic [3:0] OP_MUL = 4'd8;
    localparam int         W2     = 2 * WIDTH;

    logic [0:0]       state_q, state_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic [W2-1:0]    mcand_q, mcand_d, prod_q, prod_d, prod_nx;
    logic [WIDTH-1:0] mplier_q, mplier_d;
    logic [WIDTH-1:0] res_q, res_d;
    logic             carry_q, carry_d, zero_q, zero_d, neg_q, neg_d;
    logic             ovf_q, ovf_d, err_q, err_d, vld_q, vld_d;
    logic [WIDTH-1:0] opa, alu_res, ld_res, diff;
    logic [WIDTH:0]   sum;
    logic             alu_c, alu_v, alu_e, ld_c;
    logic             accept, alu_load, mul_start, mul_busy, mul_done, load;

`ifdef ALU_ACC_EN
    logic [WIDTH-1:0] acc_q, acc_d;
    assign opa   = use_acc ? acc_q : a;
    assign acc_d = load ? ld_res : acc_q;
    always_ff @(posedge clk) begin
        acc_q <= !rst_n ? '0 : acc_d;
    end
`else
    assign opa = a;
`endif

    assign in_ready  = (state_q == S_IDLE) && (!vld_q || out_ready);
    assign accept    = in_valid && in_ready;
    assign alu_load  = accept && (op != OP_MUL);
    assign mul_start = accept && (op == OP_MUL);
    assign mul_busy  = state_q == S_MUL;
    assign mul_done  = mul_busy && (cnt_q == CNT_W'(WIDTH - 1));
    assign load      = alu_load || mul_done;
    // One partial product per cycle: multiplicand walks left while multiplier walks right.
    assign prod_nx   = prod_q + (mplier_q[0] ? mcand_q : '0);
    assign ld_res    = mul_done ? prod_nx[WIDTH-1:0] : alu_res;
    assign ld_c      = mul_done ? |prod_nx[W2-1:WIDTH] : alu_c;

    always_comb begin
        sum     = {1'b0, opa} + {1'b0, b};
        diff    = opa - b;
        alu_res = '0;
        alu_c   = 1'b0;
        alu_v   = 1'b0;
        alu_e   = 1'b0;
        case (op)
            OP_ADD: begin
                alu_res = sum[WIDTH-1:0];
                alu_c   = sum[WIDTH];
                alu_v   = (opa[WIDTH-1] == b[WIDTH-1]) && (sum[WIDTH-1] != opa[WIDTH-1]);
            end
            OP_SUB: begin
                alu_res = diff;
                alu_c   = opa < b;
                alu_v   = (opa[WIDTH-1] != b[WIDTH-1]) && (diff[WIDTH-1] != opa[WIDTH-1]);
            end
            OP_AND: alu_res = opa & b;
            OP_OR:  alu_res = opa | b;
            OP_XOR: alu_res = opa ^ b;
            OP_NOT: alu_res = ~opa;
            OP_SHL: begin
                alu_res = {opa[WIDTH-2:0], 1'b0};
                alu_c   = opa[WIDTH-1];
            end
            OP_SHR: begin
                alu_res = {1'b0, opa[WIDTH-1:1]};
                alu_c   = opa[0];
            end
            OP_MUL: alu_e = 1'b0;
            default: alu_e = 1'b1;
        endcase
    end

    always_comb begin
        state_d  = mul_start ? S_MUL : mul_done ? S_IDLE : state_q;
        cnt_d    = mul_start ? '0 : (mul_busy && !mul_done) ? cnt_q + 1'b1 : '0;
        mcand_d  = mul_start ? {{WIDTH{1'b0}}, opa} : mul_busy ? mcand_q << 1 : mcand_q;
        mplier_d = mul_start ? b : mul_busy ? mplier_q >> 1 : mplier_q;
        prod_d   = mul_start ? '0 : mul_busy ? prod_nx : prod_q;
        vld_d    = load ? 1'b1 : out_ready ? 1'b0 : vld_q;
        res_d    = load ? ld_res : res_q;
        carry_d  = load ? ld_c : carry_q;
        zero_d   = load ? (ld_res == '0) : zero_q;
        neg_d    = load ? ld_res[WIDTH-1] : neg_q;
        ovf_d    = load ? (!mul_done && alu_v) : ovf_q;
        err_d    = load ? (!mul_done && alu_e) : err_q;
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q  <= S_IDLE;
            cnt_q    <= '0;
            mcand_q  <= '0;
            mplier_q <= '0;
            prod_q   <= '0;
            vld_q    <= 1'b0;
            res_q    <= '0;
            carry_q  <= 1'b0;
            zero_q   <= 1'b0;
            neg_q    <= 1'b0;
            ovf_q    <= 1'b0;
            err_q    <= 1'b0;
        end else begin
            state_q  <= state_d;
            cnt_q    <= cnt_d;
            mcand_q  <= mcand_d;
            mplier_q <= mplier_d;
            prod_q   <= prod_d;
            vld_q    <= vld_d;
            res_q    <= res_d;
            carry_q  <= carry_d;
            zero_q   <= zero_d;
            neg_q    <= neg_d;
            ovf_q    <= ovf_d;
            err_q    <= err_d;
        end
    end

    assign out_valid = vld_q;
    assign result    = res_q;
    assign carry     = carry_q;
    assign zero      = zero_q;
    assign neg       = neg_q;
    assign ovf       = ovf_q;
    assign err       = err_q && vld_q;
endmodule

// File: tb/tb_alu_seq.sv
// tb_alu_seq: directed vectors for alu_seq (WIDTH=8) with a queued scoreboard and a decoupled monitor.
module tb_alu_seq;
    typedef struct packed {
        logic [7:0] r;
        logic       c;
        logic       z;
        logic       n;
        logic       v;
        logic       e;
    } exp_t;

    logic       clk = 1'b0;
    logic       rst_n = 1'b0;
    logic       in_valid = 1'b0;
    logic       out_ready = 1'b1;
    logic [7:0] a = '0;
    logic [7:0] b = '0;
    logic [3:0] op = '0;
    logic       in_ready, out_valid, carry, zero, neg, ovf, err;
    logic [7:0] result;
`ifdef ALU_ACC_EN
    logic       use_acc = 1'b0;
`endif

    exp_t q[$];
    exp_t mon_got, mon_exp;
    int   checks = 0;
    int   failures = 0;

    alu_seq #(.WIDTH(8)) dut (
        .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(in_ready),
        .a(a), .b(b), .op(op),
`ifdef ALU_ACC_EN
        .use_acc(use_acc),
`endif
        .out_valid(out_valid), .out_ready(out_ready), .result(result),
        .carry(carry), .zero(zero), .neg(neg), .ovf(ovf), .err(err)
    );

    always #5 clk = ~clk;

    function automatic exp_t mk(input logic [7:0] r, input logic c, z, n, v, e);
        return {r, c, z, n, v, e};
    endfunction

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
        checks++;
        if (act !== req) begin
            failures++;
            $display("FAIL %s actual=%0h required=%0h", name, act, req);
        end
    endtask

    // Monitor: every consumed result is compared against the oldest expectation.
    always @(negedge clk) begin
        if (rst_n && out_valid && out_ready) begin
            mon_got = {result, carry, zero, neg, ovf, err};
            if (q.size() == 0) begin
                checks++;
                failures++;
                $display("FAIL unexpected_result actual=%0h required=none", mon_got);
            end else begin
                mon_exp = q.pop_front();
                check("result_flags", 32'(mon_got), 32'(mon_exp));
            end
        end
    end

    task automatic issue(input logic [3:0] o, input logic [7:0] x, input logic [7:0] y,
                         input bit push, input exp_t e, input bit post);
        int n = 0;
        op = o;
        a = x;
        b = y;
        in_valid = 1'b1;
        do begin
            @(negedge clk);
            n++;
        end while (!in_ready && n < 100);
        check("accept_in_ready", 32'(in_ready), 32'd1);
        @(posedge clk);
        if (push) q.push_back(e);
        #1;
        in_valid = 1'b0;
        a = 8'($urandom);
        b = 8'($urandom);
        if (post && o == 4'd8) begin
            for (int k = 0; k < 8; k++) begin
                @(negedge clk);
                check("mul_busy_in_ready", 32'(in_ready), 32'd0);
                check("mul_busy_out_valid", 32'(out_valid), 32'd0);
                @(posedge clk);
                #1;
            end
            @(negedge clk);
            check("mul_done_out_valid", 32'(out_valid), 32'd1);
            @(posedge clk);
            #1;
        end else if (post) begin
            @(negedge clk);
            check("latency1_out_valid", 32'(out_valid), 32'd1);
            @(posedge clk);
            #1;
        end
    endtask

    initial begin
        int n;
        in_valid = 1'b1;
        a = 8'h01;
        b = 8'h01;
        @(posedge clk);
        #1;
        @(negedge clk);
        check("rst_out_valid", 32'(out_valid), 32'd0);
        check("rst_result", 32'(result), 32'd0);
        check("rst_flags", 32'({carry, zero, neg, ovf, err}), 32'd0);
        @(posedge clk);
        #1;
        in_valid = 1'b0;
        rst_n = 1'b1;
        @(negedge clk);
        check("post_rst_in_ready", 32'(in_ready), 32'd1);
        check("post_rst_out_valid", 32'(out_valid), 32'd0);
        @(posedge clk);
        #1;

        issue(4'd0, 8'hFF, 8'h01, 1, mk(8'h00, 1, 1, 0, 0, 0), 1);
        issue(4'd0, 8'h7F, 8'h01, 1, mk(8'h80, 0, 0, 1, 1, 0), 1);
        issue(4'd1, 8'h01, 8'h02, 1, mk(8'hFF, 1, 0, 1, 0, 0), 1);
        issue(4'd1, 8'h80, 8'h01, 1, mk(8'h7F, 0, 0, 0, 1, 0), 1);
        issue(4'd6, 8'h80, 8'h00, 1, mk(8'h00, 1, 1, 0, 0, 0), 1);
        issue(4'd7, 8'h01, 8'h00, 1, mk(8'h00, 1, 1, 0, 0, 0), 1);
        // back-to-back logic ops without waiting between accepts
        issue(4'd2, 8'hF0, 8'h3C, 1, mk(8'h30, 0, 0, 0, 0, 0), 0);
        issue(4'd3, 8'hF0, 8'h0F, 1, mk(8'hFF, 0, 0, 1, 0, 0), 0);
        issue(4'd4, 8'hAA, 8'hFF, 1, mk(8'h55, 0, 0, 0, 0, 0), 0);
        issue(4'd5, 8'h0F, 8'h00, 1, mk(8'hF0, 0, 0, 1, 0, 0), 1);
        issue(4'd8, 8'h10, 8'h10, 1, mk(8'h00, 1, 1, 0, 0, 0), 1);
        issue(4'd8, 8'h0C, 8'h0B, 1, mk(8'h84, 0, 0, 1, 0, 0), 1);
        issue(4'd10, 8'h12, 8'h34, 1, mk(8'h00, 0, 1, 0, 0, 1), 1);

        out_ready = 1'b0;
        issue(4'd0, 8'h02, 8'h02, 1, mk(8'h04, 0, 0, 0, 0, 0), 1);
        for (int k = 0; k < 5; k++) begin
            @(negedge clk);
            check("stall_in_ready", 32'(in_ready), 32'd0);
            check("stall_out_valid", 32'(out_valid), 32'd1);
            check("stall_result", 32'(result), 32'h04);
            @(posedge clk);
            #1;
        end
        out_ready = 1'b1;
        issue(4'd0, 8'h03, 8'h03, 1, mk(8'h06, 0, 0, 0, 0, 0), 1);

        issue(4'd8, 8'h05, 8'h03, 0, mk(8'h00, 0, 0, 0, 0, 0), 0);
        repeat (4) begin
            @(posedge clk);
            #1;
        end
        rst_n = 1'b0;
        @(posedge clk);
        #1;
        rst_n = 1'b1;
        @(negedge clk);
        check("mul_abort_in_ready", 32'(in_ready), 32'd1);
        check("mul_abort_out_valid", 32'(out_valid), 32'd0);
        check("mul_abort_result", 32'(result), 32'd0);
        for (int k = 0; k < 10; k++) begin
            @(negedge clk);
            check("mul_abort_quiet", 32'(out_valid), 32'd0);
        end
        @(posedge clk);
        #1;
        issue(4'd15, 8'hFF, 8'hFF, 1, mk(8'h00, 0, 1, 0, 0, 1), 1);

`ifdef ALU_ACC_EN
        issue(4'd0, 8'h05, 8'h00, 1, mk(8'h05, 0, 0, 0, 0, 0), 1);
        use_acc = 1'b1;
        issue(4'd0, 8'hEE, 8'h03, 1, mk(8'h08, 0, 0, 0, 0, 0), 1);
        use_acc = 1'b0;
`endif

        n = 0;
        while (q.size() != 0 && n < 50) begin
            @(posedge clk);
            n++;
        end
        check("queue_drained", 32'(q.size()), 32'd0);
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
